// File: rtl/birukee_mm_dma_ctrl_if.sv
// Bundle of DMA, datapath and configuration signals around the matrix-multiply sequencer.
// The master modport is the sequencer side; slave is the DMA engine/datapath/config side.
interface birukee_mm_dma_ctrl_if #(
    parameter int MAX_N     = 8,
    parameter int IN_WIDTH  = 16,
    parameter int OUT_WIDTH = 32
);
    localparam int RW = (MAX_N > 1) ? $clog2(MAX_N) : 1;
    localparam int NW = $clog2(MAX_N + 1);

    logic                 conf_done;
    logic [31:0]          conf_info_matrix_size;
    logic [31:0]          conf_info_input1;
    logic [31:0]          conf_info_input2;
    logic [31:0]          conf_info_output;

    logic                 dma_read_ctrl_valid;
    logic                 dma_read_ctrl_ready;
    logic [31:0]          dma_read_ctrl_data_index;
    logic [31:0]          dma_read_ctrl_data_length;
    logic [2:0]           dma_read_ctrl_data_size;
    logic                 dma_read_chnl_valid;
    logic                 dma_read_chnl_ready;
    logic [63:0]          dma_read_chnl_data;

    logic                 dma_write_ctrl_valid;
    logic                 dma_write_ctrl_ready;
    logic [31:0]          dma_write_ctrl_data_index;
    logic [31:0]          dma_write_ctrl_data_length;
    logic [2:0]           dma_write_ctrl_data_size;
    logic                 dma_write_chnl_valid;
    logic                 dma_write_chnl_ready;
    logic [63:0]          dma_write_chnl_data;

    logic                 ld_valid;
    logic                 ld_sel;
    logic [RW-1:0]        ld_row;
    logic [RW-1:0]        ld_col;
    logic [IN_WIDTH-1:0]  ld_data;
    logic [NW-1:0]        matrix_size;
    logic                 mm_start;
    logic                 mm_done;
    logic                 res_valid;
    logic                 res_ready;
    logic [OUT_WIDTH-1:0] res_data;
    logic                 acc_done;
    logic [31:0]          debug;

    modport master (
        input  conf_done, conf_info_matrix_size, conf_info_input1, conf_info_input2, conf_info_output,
        output dma_read_ctrl_valid, dma_read_ctrl_data_index, dma_read_ctrl_data_length,
        output dma_read_ctrl_data_size, dma_read_chnl_ready,
        input  dma_read_ctrl_ready, dma_read_chnl_valid, dma_read_chnl_data,
        output dma_write_ctrl_valid, dma_write_ctrl_data_index, dma_write_ctrl_data_length,
        output dma_write_ctrl_data_size, dma_write_chnl_valid, dma_write_chnl_data,
        input  dma_write_ctrl_ready, dma_write_chnl_ready,
        output ld_valid, ld_sel, ld_row, ld_col, ld_data, matrix_size, mm_start,
        output res_ready, acc_done, debug,
        input  mm_done, res_valid, res_data
    );

    modport slave (
        output conf_done, conf_info_matrix_size, conf_info_input1, conf_info_input2, conf_info_output,
        input  dma_read_ctrl_valid, dma_read_ctrl_data_index, dma_read_ctrl_data_length,
        input  dma_read_ctrl_data_size, dma_read_chnl_ready,
        output dma_read_ctrl_ready, dma_read_chnl_valid, dma_read_chnl_data,
        input  dma_write_ctrl_valid, dma_write_ctrl_data_index, dma_write_ctrl_data_length,
        input  dma_write_ctrl_data_size, dma_write_chnl_valid, dma_write_chnl_data,
        output dma_write_ctrl_ready, dma_write_chnl_ready,
        input  ld_valid, ld_sel, ld_row, ld_col, ld_data, matrix_size, mm_start,
        input  res_ready, acc_done, debug,
        output mm_done, res_valid, res_data
    );
endinterface

// File: rtl/birukee_mm_dma_ctrl.sv
// Matrix-multiply sequencer: DMA-load both operands, start the systolic array,
// wait for completion, then DMA-store the N*N result.
module birukee_mm_dma_ctrl #(
    parameter int MAX_N     = 8,
    parameter int IN_WIDTH  = 16,
    parameter int OUT_WIDTH = 32
) (
    input  logic                         clk,
    input  logic                         rst_n,
    birukee_mm_dma_ctrl_if.master        bus
);
    localparam int RW = (MAX_N > 1) ? $clog2(MAX_N) : 1;
    localparam int NW = $clog2(MAX_N + 1);
    localparam int BW = 2 * NW;

    typedef enum logic [3:0] {
        S_IDLE, S_RD1_REQ, S_RD1_DAT, S_RD2_REQ, S_RD2_DAT,
        S_START, S_WAIT, S_WR_REQ, S_WR_DAT, S_DONE
    } state_t;

    state_t          r_state;
    state_t          w_state_next;
    logic [NW-1:0]   r_n;
    logic [31:0]     r_in1;
    logic [31:0]     r_in2;
    logic [31:0]     r_out;
    logic            r_err;
    logic [RW-1:0]   r_row;
    logic [RW-1:0]   r_col;
    logic [BW-1:0]   r_beat;
    logic            r_done_seen;

    logic [BW-1:0]   w_len;
    logic            w_cfg_ok;
    logic            w_rd_dat;
    logic            w_rd_fire;
    logic            w_wr_fire;
    logic            w_last;

    assign w_len     = BW'(r_n) * BW'(r_n);
    assign w_cfg_ok  = (bus.conf_info_matrix_size != 32'd0) &&
                       (bus.conf_info_matrix_size <= 32'(MAX_N));
    assign w_rd_dat  = (r_state == S_RD1_DAT) || (r_state == S_RD2_DAT);
    assign w_rd_fire = w_rd_dat && bus.dma_read_chnl_valid;
    assign w_wr_fire = (r_state == S_WR_DAT) && bus.res_valid && bus.dma_write_chnl_ready;
    assign w_last    = (r_beat == (w_len - BW'(1)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:    if (bus.conf_done) w_state_next = w_cfg_ok ? S_RD1_REQ : S_DONE;
            S_RD1_REQ: if (bus.dma_read_ctrl_ready) w_state_next = S_RD1_DAT;
            S_RD1_DAT: if (w_rd_fire && w_last) w_state_next = S_RD2_REQ;
            S_RD2_REQ: if (bus.dma_read_ctrl_ready) w_state_next = S_RD2_DAT;
            S_RD2_DAT: if (w_rd_fire && w_last) w_state_next = S_START;
            S_START:   w_state_next = S_WAIT;
            S_WAIT:    if (bus.mm_done || r_done_seen) w_state_next = S_WR_REQ;
            S_WR_REQ:  if (bus.dma_write_ctrl_ready) w_state_next = S_WR_DAT;
            S_WR_DAT:  if (w_wr_fire && w_last) w_state_next = S_DONE;
            S_DONE:    w_state_next = S_IDLE;
            default:   w_state_next = S_IDLE;
        endcase
    end

    // Config latch, element coordinates and the shared beat counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_n         <= '0;
            r_in1       <= '0;
            r_in2       <= '0;
            r_out       <= '0;
            r_err       <= 1'b0;
            r_row       <= '0;
            r_col       <= '0;
            r_beat      <= '0;
            r_done_seen <= 1'b0;
        end else begin
            if ((r_state == S_IDLE) && bus.conf_done) begin
                if (w_cfg_ok) begin
                    r_n   <= NW'(bus.conf_info_matrix_size);
                    r_in1 <= bus.conf_info_input1;
                    r_in2 <= bus.conf_info_input2;
                    r_out <= bus.conf_info_output;
                    r_err <= 1'b0;
                end else begin
                    r_err <= 1'b1;
                end
            end
            if (w_rd_fire) begin
                if (w_last) begin
                    r_beat <= '0;
                    r_row  <= '0;
                    r_col  <= '0;
                end else begin
                    r_beat <= r_beat + BW'(1);
                    if (r_col == RW'(r_n - NW'(1))) begin
                        r_col <= '0;
                        r_row <= r_row + RW'(1);
                    end else begin
                        r_col <= r_col + RW'(1);
                    end
                end
            end else if (w_wr_fire) begin
                r_beat <= w_last ? '0 : (r_beat + BW'(1));
            end
            // A completion pulse coinciding with the start pulse must not be lost.
            if (r_state == S_START) begin
                r_done_seen <= bus.mm_done;
            end else if (r_state == S_WAIT) begin
                r_done_seen <= 1'b0;
            end
        end
    end

    always_comb begin
        bus.dma_read_ctrl_valid        = 1'b0;
        bus.dma_read_ctrl_data_index   = 32'd0;
        bus.dma_read_ctrl_data_length  = 32'd0;
        bus.dma_read_ctrl_data_size    = 3'b000;
        bus.dma_read_chnl_ready        = w_rd_dat;
        bus.dma_write_ctrl_valid       = 1'b0;
        bus.dma_write_ctrl_data_index  = 32'd0;
        bus.dma_write_ctrl_data_length = 32'd0;
        bus.dma_write_ctrl_data_size   = 3'b000;
        bus.dma_write_chnl_valid       = 1'b0;
        bus.dma_write_chnl_data        = 64'd0;
        bus.res_ready                  = 1'b0;
        bus.ld_valid                   = w_rd_fire;
        bus.ld_sel                     = (r_state == S_RD2_DAT);
        bus.ld_row                     = r_row;
        bus.ld_col                     = r_col;
        bus.ld_data                    = w_rd_fire ? bus.dma_read_chnl_data[IN_WIDTH-1:0] : '0;
        bus.matrix_size                = r_n;
        bus.mm_start                   = (r_state == S_START);
        bus.acc_done                   = (r_state == S_DONE);
        bus.debug                      = {30'd0, r_err, (r_state != S_IDLE) && (r_state != S_DONE)};
        case (r_state)
            S_RD1_REQ, S_RD2_REQ: begin
                bus.dma_read_ctrl_valid       = 1'b1;
                bus.dma_read_ctrl_data_index  = (r_state == S_RD1_REQ) ? r_in1 : r_in2;
                bus.dma_read_ctrl_data_length = 32'(w_len);
                bus.dma_read_ctrl_data_size   = 3'b011;
            end
            S_WR_REQ: begin
                bus.dma_write_ctrl_valid       = 1'b1;
                bus.dma_write_ctrl_data_index  = r_out;
                bus.dma_write_ctrl_data_length = 32'(w_len);
                bus.dma_write_ctrl_data_size   = 3'b011;
            end
            S_WR_DAT: begin
                bus.dma_write_chnl_valid = bus.res_valid;
                bus.dma_write_chnl_data  = {{(64-OUT_WIDTH){1'b0}}, bus.res_data};
                bus.res_ready            = bus.dma_write_chnl_ready;
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_birukee_mm_dma_ctrl.sv
// Directed bench for the matrix-multiply sequencer: job table plus hand-written
// sequences for request back-pressure, mid-job reset and conf_done while computing.
module tb_birukee_mm_dma_ctrl;
    localparam int MAX_N     = 8;
    localparam int IN_WIDTH  = 16;
    localparam int OUT_WIDTH = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    birukee_mm_dma_ctrl_if #(.MAX_N(MAX_N), .IN_WIDTH(IN_WIDTH), .OUT_WIDTH(OUT_WIDTH)) bus ();
    birukee_mm_dma_ctrl #(.MAX_N(MAX_N), .IN_WIDTH(IN_WIDTH), .OUT_WIDTH(OUT_WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_vec = 0;
    int n_bad = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // current job, as the bench expects it
    int job_n = 0, job_nn = 0, job_in1 = 0, job_in2 = 0, job_out = 0;
    bit stall = 1'b0;
    bit rd_hold = 1'b0;
    int mm_lat = 2;
    int res_k = 0;
    int conf_cyc = 0;

    // observations
    int n_ld = 0, n_wr = 0, n_start = 0, n_acc = 0, n_rdreq = 0, n_wrreq = 0, acc_cyc = 0;
    bit any_ctrl = 1'b0;
    bit saw_sel1 = 1'b0;

    typedef struct {
        int n; int in1; int in2; int outb; bit stall; int lat;
        int exp_ld; int exp_wr; int exp_start; int exp_req; bit exp_err;
    } job_t;
    job_t jobs[6];

    function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endfunction

    function automatic logic [63:0] rd_word(int idx);
        logic [15:0] i16;
        i16 = idx[15:0];
        return {16'hBEEF, i16, 16'h1234, i16 * 16'd7 + 16'd5};
    endfunction

    function automatic logic [31:0] res_word(int k);
        return 32'hC0DE_0000 ^ (32'(k) * 32'h0001_0003);
    endfunction

    function automatic logic outs_or();
        return |{bus.dma_read_ctrl_valid, bus.dma_read_ctrl_data_index, bus.dma_read_ctrl_data_length,
                 bus.dma_read_ctrl_data_size, bus.dma_read_chnl_ready, bus.dma_write_ctrl_valid,
                 bus.dma_write_ctrl_data_index, bus.dma_write_ctrl_data_length,
                 bus.dma_write_ctrl_data_size, bus.dma_write_chnl_valid, bus.dma_write_chnl_data,
                 bus.ld_valid, bus.ld_sel, bus.ld_row, bus.ld_col, bus.ld_data, bus.matrix_size,
                 bus.mm_start, bus.res_ready, bus.acc_done, bus.debug};
    endfunction

    // read DMA engine
    initial begin : rd_resp
        int len, base, k;
        len = 0; base = 0; k = 0;
        bus.dma_read_ctrl_ready = 1'b0;
        bus.dma_read_chnl_valid = 1'b0;
        bus.dma_read_chnl_data  = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                len = 0; k = 0;
            end else if (bus.dma_read_ctrl_valid && bus.dma_read_ctrl_ready) begin
                base = int'(bus.dma_read_ctrl_data_index);
                len  = int'(bus.dma_read_ctrl_data_length);
                k    = 0;
            end else if (bus.dma_read_chnl_valid && bus.dma_read_chnl_ready) begin
                k++;
            end
            @(posedge clk); #1;
            bus.dma_read_ctrl_ready = rd_hold ? 1'b0 : (stall ? 1'($urandom_range(0, 1)) : 1'b1);
            bus.dma_read_chnl_valid = (k < len) && (stall ? ($urandom_range(0, 2) != 0) : 1'b1);
            bus.dma_read_chnl_data  = rd_word(base + k);
        end
    end

    // write DMA engine and result stream source
    initial begin : wr_resp
        bus.dma_write_ctrl_ready = 1'b0;
        bus.dma_write_chnl_ready = 1'b0;
        bus.res_valid = 1'b0;
        bus.res_data  = '0;
        forever begin
            @(negedge clk);
            if (rst_n && bus.res_valid && bus.res_ready) res_k++;
            @(posedge clk); #1;
            bus.dma_write_ctrl_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            bus.dma_write_chnl_ready = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
            bus.res_valid = (res_k < job_nn) && (stall ? ($urandom_range(0, 2) != 0) : 1'b1);
            bus.res_data  = res_word(res_k);
        end
    end

    // systolic datapath completion
    initial begin : cmp_resp
        bus.mm_done = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_n && bus.mm_start) begin
                if (mm_lat == 0) begin
                    bus.mm_done = 1'b1;
                end else begin
                    repeat (mm_lat) @(posedge clk);
                    #1 bus.mm_done = 1'b1;
                end
                @(posedge clk); #1;
                bus.mm_done = 1'b0;
            end
        end
    end

    // per-beat checks against the bench's own job model
    initial begin : mon
        logic [63:0] w;
        int k, sel;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (bus.dma_read_ctrl_valid || bus.dma_write_ctrl_valid) any_ctrl = 1'b1;
                if (bus.dma_read_ctrl_valid && bus.dma_read_ctrl_ready) begin
                    chk("rd_req_index", bus.dma_read_ctrl_data_index, (n_rdreq == 0) ? job_in1 : job_in2);
                    chk("rd_req_length", bus.dma_read_ctrl_data_length, job_nn);
                    chk("rd_req_size", bus.dma_read_ctrl_data_size, 3'b011);
                    n_rdreq++;
                end
                if (bus.ld_valid || (bus.dma_read_chnl_valid && bus.dma_read_chnl_ready)) begin
                    chk("ld_valid_vs_beat", bus.ld_valid, bus.dma_read_chnl_valid && bus.dma_read_chnl_ready);
                    if (job_nn > 0) begin
                        sel = n_ld / job_nn;
                        k   = n_ld % job_nn;
                        w   = rd_word(((sel != 0) ? job_in2 : job_in1) + k);
                        chk("ld_beat",
                            (64'(bus.ld_sel) << 40) | (64'(bus.ld_row) << 32) | (64'(bus.ld_col) << 24) | 64'(bus.ld_data),
                            (64'(sel) << 40) | (64'(k / job_n) << 32) | (64'(k % job_n) << 24) | 64'(w[15:0]));
                    end
                    if (bus.ld_valid) begin
                        n_ld++;
                        if (bus.ld_sel) saw_sel1 = 1'b1;
                    end
                end
                if (bus.dma_write_ctrl_valid && bus.dma_write_ctrl_ready) begin
                    chk("wr_req_index", bus.dma_write_ctrl_data_index, job_out);
                    chk("wr_req_length", bus.dma_write_ctrl_data_length, job_nn);
                    n_wrreq++;
                end
                if (bus.dma_write_chnl_valid && bus.dma_write_chnl_ready) begin
                    chk("wr_beat", bus.dma_write_chnl_data, {32'd0, res_word(n_wr)});
                    n_wr++;
                end
                if (bus.mm_start) n_start++;
                if (bus.acc_done) begin
                    n_acc++;
                    acc_cyc = cyc;
                end
            end
        end
    end

    task automatic kick(int n, int in1, int in2, int outb);
        job_n = n; job_in1 = in1; job_in2 = in2; job_out = outb;
        job_nn = (n >= 1 && n <= MAX_N) ? n * n : 0;
        n_ld = 0; n_wr = 0; n_start = 0; n_acc = 0; n_rdreq = 0; n_wrreq = 0;
        any_ctrl = 1'b0; saw_sel1 = 1'b0; res_k = 0;
        bus.conf_info_matrix_size = n;
        bus.conf_info_input1 = in1;
        bus.conf_info_input2 = in2;
        bus.conf_info_output = outb;
        bus.conf_done = 1'b1;
        conf_cyc = cyc;
        @(posedge clk); #1;
        bus.conf_done = 1'b0;
        bus.conf_info_matrix_size = 32'd5;
        bus.conf_info_input1 = 32'hDEAD_0001;
        bus.conf_info_input2 = 32'hDEAD_0002;
        bus.conf_info_output = 32'hDEAD_0003;
    endtask

    task automatic wait_acc(int budget);
        int t;
        t = 0;
        while (n_acc == 0 && t < budget) begin
            @(posedge clk); #1;
            t++;
        end
        repeat (4) @(posedge clk);
        #1;
    endtask

    initial begin : main
        int t;
        jobs[0] = '{2, 'h100,  'h200,  'h300,  1'b0, 2, 8,   4,  1, 3, 1'b0};
        jobs[1] = '{8, 'h1000, 'h2000, 'h3000, 1'b1, 3, 128, 64, 1, 3, 1'b0};
        jobs[2] = '{0, 'h10,   'h20,   'h30,   1'b0, 2, 0,   0,  0, 0, 1'b1};
        jobs[3] = '{9, 'h10,   'h20,   'h30,   1'b0, 2, 0,   0,  0, 0, 1'b1};
        jobs[4] = '{1, 'h77,   'h88,   'h99,   1'b0, 1, 2,   1,  1, 3, 1'b0};
        jobs[5] = '{3, 'h400,  'h500,  'h600,  1'b1, 0, 18,  9,  1, 3, 1'b0};

        bus.conf_done = 1'b0;
        bus.conf_info_matrix_size = '0;
        bus.conf_info_input1 = '0;
        bus.conf_info_input2 = '0;
        bus.conf_info_output = '0;

        repeat (3) @(negedge clk);
        chk("reset_outputs_or", 64'(outs_or()), 64'd0);
        chk("reset_debug", bus.debug, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        for (int i = 0; i < 6; i++) begin
            stall  = jobs[i].stall;
            mm_lat = jobs[i].lat;
            kick(jobs[i].n, jobs[i].in1, jobs[i].in2, jobs[i].outb);
            wait_acc(4000);
            chk($sformatf("job%0d_loads", i), n_ld, jobs[i].exp_ld);
            chk($sformatf("job%0d_writes", i), n_wr, jobs[i].exp_wr);
            chk($sformatf("job%0d_starts", i), n_start, jobs[i].exp_start);
            chk($sformatf("job%0d_requests", i), n_rdreq + n_wrreq, jobs[i].exp_req);
            chk($sformatf("job%0d_ctrl_seen", i), 64'(any_ctrl), 64'(jobs[i].exp_req > 0));
            chk($sformatf("job%0d_acc_done", i), n_acc, 1);
            chk($sformatf("job%0d_debug", i), bus.debug, {30'd0, jobs[i].exp_err, 1'b0});
            if (jobs[i].exp_err) chk($sformatf("job%0d_err_latency", i), acc_cyc - conf_cyc, 1);
        end

        // read request held off for 10 cycles
        stall = 1'b0; mm_lat = 2; rd_hold = 1'b1;
        kick(2, 'h500, 'h600, 'h700);
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            chk("hold_valid_ldvalid", {bus.dma_read_ctrl_valid, bus.ld_valid}, 2'b10);
            chk("hold_index_length", {bus.dma_read_ctrl_data_index, bus.dma_read_ctrl_data_length},
                {32'h500, 32'd4});
            @(posedge clk); #1;
        end
        chk("hold_matrix_size", bus.matrix_size, 4'd2);
        rd_hold = 1'b0;
        wait_acc(2000);
        chk("hold_loads", n_ld, 8);
        chk("hold_acc_done", n_acc, 1);

        // reset while matrix 2 is streaming in
        stall = 1'b1; mm_lat = 2;
        kick(4, 'h1000, 'h2000, 'h3000);
        t = 0;
        while (!saw_sel1 && t < 2000) begin
            @(posedge clk); #1;
            t++;
        end
        chk("rd2_reached", 64'(saw_sel1), 64'd1);
        rst_n = 1'b0;
        @(negedge clk);
        chk("midreset_outputs_or", 64'(outs_or()), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        stall = 1'b0;
        @(posedge clk); #1;
        kick(2, 'h100, 'h200, 'h300);
        wait_acc(2000);
        chk("after_reset_loads", n_ld, 8);
        chk("after_reset_writes", n_wr, 4);
        chk("after_reset_acc", n_acc, 1);

        // conf_done while waiting on the datapath is ignored
        stall = 1'b0; mm_lat = 8;
        kick(3, 'h40, 'h80, 'hC0);
        t = 0;
        while (n_start == 0 && t < 2000) begin
            @(posedge clk); #1;
            t++;
        end
        bus.conf_info_matrix_size = 32'd2;
        bus.conf_info_input1 = 32'h999;
        bus.conf_info_output = 32'h777;
        bus.conf_done = 1'b1;
        @(posedge clk); #1;
        bus.conf_done = 1'b0;
        wait_acc(2000);
        repeat (6) @(posedge clk);
        #1;
        chk("wait_conf_loads", n_ld, 18);
        chk("wait_conf_writes", n_wr, 9);
        chk("wait_conf_requests", n_rdreq + n_wrreq, 3);
        chk("wait_conf_acc", n_acc, 1);
        chk("wait_conf_idle", bus.debug, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got no summary, expected completion");
        $fatal(1, "watchdog");
    end
endmodule
